// File: rtl/mbinit_sb_responder.sv
// mbinit_sb_responder: partner-side MBINIT sideband responder; define MBINIT_REVERSAL_EN to support the REVERSALMB substate
package mbinit_sb_pkg;
  typedef enum logic [4:0] {
    NOP,
    PARAM_CONFIG_REQ, PARAM_CONFIG_RESP,
    CAL_DONE_REQ, CAL_DONE_RESP,
    REPAIRCLK_INIT_REQ, REPAIRCLK_INIT_RESP,
    REPAIRCLK_RESULT_REQ, REPAIRCLK_RESULT_RESP,
    REPAIRCLK_DONE_REQ, REPAIRCLK_DONE_RESP,
    REPAIRVAL_INIT_REQ, REPAIRVAL_INIT_RESP,
    REPAIRVAL_RESULT_REQ, REPAIRVAL_RESULT_RESP,
    REPAIRVAL_DONE_REQ, REPAIRVAL_DONE_RESP,
    REVERSALMB_INIT_REQ, REVERSALMB_INIT_RESP,
    REVERSALMB_CLEAR_ERROR_REQ, REVERSALMB_CLEAR_ERROR_RESP,
    REVERSALMB_RESULT_REQ, REVERSALMB_RESULT_RESP,
    REVERSALMB_DONE_REQ, REVERSALMB_DONE_RESP,
    REPAIRMB_START_REQ, REPAIRMB_START_RESP,
    REPAIRMB_END_REQ, REPAIRMB_END_RESP
  } SB_msg_t;
endpackage

module mbinit_sb_responder
  import mbinit_sb_pkg::*;
#(
  parameter logic [3:0] LOCAL_MAX_RATE = 4'd5,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        enable_i,
  input  SB_msg_t     SB_RX_msg_i,
  input  logic [63:0] SB_RX_dataBus_i,
  output logic        SB_RX_msg_req_o,
  input  logic        SB_RX_msg_valid_i,
  output SB_msg_t     SB_TX_msg_o,
  output logic [63:0] SB_TX_dataBus_o,
  output logic        SB_TX_msg_valid_o,
  input  logic        SB_TX_msg_sendNextFlag_i,
  input  logic [2:0]  clk_result_i,
  input  logic        val_result_i,
  input  logic [15:0] data_result_i,
  output logic [2:0]  substate_o,
  output logic        responder_done_o,
  output logic        error_o,
  output logic        reset_state_timeout_counter_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, WAIT_REQ, DECODE, SEND, DONE, ERROR} state_t;
  state_t state, state_nxt;
  logic [2:0] sub, sub_nxt, sub_step;
  SB_msg_t rx_msg, tx_msg, resp_msg;
  logic [63:0] rx_data, tx_data, resp_data;
  logic [CW-1:0] cnt;
  logic [3:0] rate;
  logic accept, legal, advance, timeout;
  assign accept = state == WAIT_REQ && SB_RX_msg_valid_i;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign rate = rx_data[3:0] > LOCAL_MAX_RATE ? LOCAL_MAX_RATE : rx_data[3:0];
  assign resp_msg = SB_msg_t'(rx_msg + 5'd1);
  assign resp_data = rx_msg == PARAM_CONFIG_REQ      ? {rx_data[63:4], rate} :
                     rx_msg == REPAIRCLK_RESULT_REQ  ? {61'd0, clk_result_i} :
                     rx_msg == REPAIRVAL_RESULT_REQ  ? {63'd0, val_result_i} :
                     rx_msg == REVERSALMB_RESULT_REQ ? {48'd0, data_result_i} : 64'd0;
  assign advance = tx_msg inside {PARAM_CONFIG_RESP, CAL_DONE_RESP, REPAIRCLK_DONE_RESP,
                                  REPAIRVAL_DONE_RESP, REVERSALMB_DONE_RESP};
`ifdef MBINIT_REVERSAL_EN
  assign sub_step = sub + 3'd1;
`else
  assign sub_step = sub == 3'd3 ? 3'd5 : sub + 3'd1;
`endif
  assign SB_RX_msg_req_o = state == WAIT_REQ;
  assign SB_TX_msg_valid_o = state == SEND;
  assign SB_TX_msg_o = state == SEND ? tx_msg : NOP;
  assign SB_TX_dataBus_o = state == SEND ? tx_data : 64'd0;
  assign responder_done_o = state == DONE;
  assign error_o = state == ERROR;
  assign reset_state_timeout_counter_o = state == DECODE;
  assign substate_o = sub;
  // request legality: INIT/RESULT repeat freely inside their substate, only the matching substate's requests are accepted
  always_comb begin
    legal = 1'b0;
    case (sub)
      3'd0: legal = rx_msg == PARAM_CONFIG_REQ;
      3'd1: legal = rx_msg == CAL_DONE_REQ;
      3'd2: legal = rx_msg inside {REPAIRCLK_INIT_REQ, REPAIRCLK_RESULT_REQ, REPAIRCLK_DONE_REQ};
      3'd3: legal = rx_msg inside {REPAIRVAL_INIT_REQ, REPAIRVAL_RESULT_REQ, REPAIRVAL_DONE_REQ};
`ifdef MBINIT_REVERSAL_EN
      3'd4: legal = rx_msg inside {REVERSALMB_INIT_REQ, REVERSALMB_CLEAR_ERROR_REQ,
                                   REVERSALMB_RESULT_REQ, REVERSALMB_DONE_REQ};
`endif
      3'd5: legal = rx_msg inside {REPAIRMB_START_REQ, REPAIRMB_END_REQ};
      default: legal = 1'b0;
    endcase
  end
  // next state and substate; dropping enable restarts the whole MBINIT exchange
  always_comb begin
    state_nxt = state;
    sub_nxt = sub;
    if (!enable_i) begin
      state_nxt = IDLE;
      sub_nxt = 3'd0;
    end else begin
      case (state)
        IDLE:     state_nxt = WAIT_REQ;
        WAIT_REQ: state_nxt = accept ? DECODE : timeout ? ERROR : WAIT_REQ;
        DECODE:   state_nxt = legal ? SEND : ERROR;
        SEND:
          if (SB_TX_msg_sendNextFlag_i) begin
            state_nxt = tx_msg == REPAIRMB_END_RESP ? DONE : WAIT_REQ;
            sub_nxt = advance ? sub_step : sub;
          end
        default:  state_nxt = state;
      endcase
    end
  end
  // state and substate registers
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      sub <= 3'd0;
    end else begin
      state <= state_nxt;
      sub <= sub_nxt;
    end
  // request capture, response build at DECODE (result inputs sampled here), and idle-wait counter
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      rx_msg <= NOP;
      rx_data <= 64'd0;
      tx_msg <= NOP;
      tx_data <= 64'd0;
      cnt <= '0;
    end else begin
      if (accept) begin
        rx_msg <= SB_RX_msg_i;
        rx_data <= SB_RX_dataBus_i;
      end
      if (state == DECODE) begin
        tx_msg <= resp_msg;
        tx_data <= resp_data;
      end
      cnt <= state == WAIT_REQ && !accept ? cnt + CW'(1) : '0;
    end
endmodule
